mem_rr_arbiter: RTL
===================

Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares one memory/IO slave port (on-chip RAM, LED register, UART) between N_REQ PicoRV32 cores using the native mem_valid/mem_ready handshake.
- Sits between the core array and the memory/IO decode logic, replacing per-cycle time slicing with request-driven grants.
- One transaction is in flight at a time. Grants rotate fairly, starting after the last granted core.

Parameters:
- N_REQ, 4, number of requesting cores (1..16).
- GID_W, $clog2(N_REQ) (minimum 1), width of the grant index.
- TIMEOUT, 255, cycles to wait for s_ready before aborting (used only with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m_valid  in  N_REQ  per-core request; held high until the matching m_ready
- m_addr  in  32*N_REQ  per-core byte address; core i uses bits [32i+31:32i]
- m_wdata  in  32*N_REQ  per-core write data
- m_wstrb  in  4*N_REQ  per-core byte strobes; 0 means read
- m_ready  out  N_REQ  per-core one-cycle completion pulse
- m_rdata  out  32  read data, shared by all cores; valid when any m_ready bit is high
- s_valid  out  1  downstream request
- s_addr  out  32  downstream address
- s_wdata  out  32  downstream write data
- s_wstrb  out  4  downstream strobes
- s_gid  out  GID_W  index of the core that owns the current transaction
- s_ready  in  1  downstream completion; sampled only while s_valid is high
- s_rdata  in  32  downstream read data; valid with s_ready
- arb_err  out  1  sticky timeout flag (tied to 0 without the macro)

Behaviour:
- Reset values: m_ready=0, m_rdata=0, s_valid=0, s_addr=0, s_wdata=0, s_wstrb=0, s_gid=0, arb_err=0, state=IDLE, last grant pointer=N_REQ-1, so core 0 has first priority.
- Reset is asynchronous. If it asserts mid-transaction, the transaction is dropped, no m_ready is issued, and all outputs take their reset values immediately.
- State machine:
  - IDLE:
    - eligible = m_valid & ~m_ready.
    - The mask blocks a core whose m_ready pulse is active this cycle, because that core has not yet dropped m_valid.
    - If any core is eligible, pick the first eligible index scanning last+1, last+2, … with wrap modulo N_REQ.
    - Register that core's addr, wdata and wstrb onto the s_* outputs, set s_gid to its index, set s_valid=1, update last to the picked index, and go to BUSY.
  - BUSY:
    - s_* outputs are held stable.
    - On s_ready=1: s_valid←0, m_rdata←s_rdata, m_ready[s_gid]←1 for exactly one cycle, then go to IDLE.
- Latency:
  - m_valid high in cycle t while IDLE gives s_valid high at t+1.
  - s_ready in cycle k gives m_ready at k+1.
  - Minimum round trip is 2 cycles plus slave latency.
- Back-to-back:
  - Arbitration happens in the same cycle that m_ready pulses, so the next grant's s_valid rises one cycle after the previous m_ready.
  - The completing core is masked for that cycle.
- Simultaneous requests: exactly one grant per arbitration, and any other core is granted at most once before a core waiting since that arbitration.
- N_REQ=1: the pointer is constant and core 0 always wins.
- m_ready never has more than one bit set. m_rdata is held between completions.
- s_ready while s_valid=0 is ignored.
- Requests that change addr/wdata while waiting are a protocol violation; the registered copy taken at grant is used.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- When defined:
  - An 8..16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT with no s_ready: s_valid←0, m_rdata←32'hDEAD_BEEF, the owning core gets m_ready, arb_err←1 (sticky until reset), and the state returns to IDLE.
  - If s_ready arrives in the same cycle the limit is reached, s_ready wins and arb_err is not set.
- When undefined:
  - No counter exists, BUSY waits indefinitely, and arb_err is constant 0.

Test Plan:
- Single read: core 2 requests addr 0x0000_0010, slave answers s_ready next cycle with 0x1234_5678 → s_valid one cycle after m_valid, s_gid=2, m_ready=4'b0100 for one cycle, m_rdata=0x1234_5678.
- All four cores request together from reset → grant order 0,1,2,3. Cores held requesting after completion → order continues 0,1,2,3 with no core granted twice in a row.
- Write path: core 1 writes 0x1000_0000 with wdata 0x0000_00A5 and wstrb 4'b0001 → s_addr, s_wdata and s_wstrb match exactly; m_ready[1] pulses; no other m_ready bit is ever set.
- Back-to-back masking: core 0 keeps m_valid high one cycle after its m_ready while core 3 is also requesting → next grant is core 3, not a duplicate grant to core 0.
- Reset mid-BUSY: assert reset while s_valid=1 → s_valid and m_ready go to 0 asynchronously; after release, core 0 has first priority.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=8, slave never answers → m_ready for the owner 8 cycles after grant, m_rdata=0xDEADBEEF, arb_err=1 and remains 1. A second run where s_ready arrives on cycle 8 → normal completion and arb_err stays 0.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory/IO slave port between N_REQ PicoRV32 cores.
// Optional slave-timeout abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int GID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     m_valid,
  input  logic [32*N_REQ-1:0]  m_addr,
  input  logic [32*N_REQ-1:0]  m_wdata,
  input  logic [4*N_REQ-1:0]   m_wstrb,
  output logic [N_REQ-1:0]     m_ready,
  output logic [31:0]          m_rdata,
  output logic                 s_valid,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_wstrb,
  output logic [GID_W-1:0]     s_gid,
  input  logic                 s_ready,
  input  logic [31:0]          s_rdata,
  output logic                 arb_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_q;
  logic [GID_W-1:0] last_q;
  logic [N_REQ-1:0] eligible;
  logic             pick_vld;
  logic [GID_W-1:0] pick_idx;

  // A core whose m_ready pulses this cycle still shows m_valid; keep it out of this round.
  assign eligible = m_valid & ~m_ready;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!pick_vld && eligible[(int'(last_q) + k) % N_REQ]) begin
        pick_vld = 1'b1;
        pick_idx = GID_W'((int'(last_q) + k) % N_REQ);
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] to_cnt_q;
  logic             arb_err_q;
  logic             to_hit;

  // Counter holds the number of BUSY cycles already elapsed, so the abort fires
  // in the TIMEOUT-th BUSY cycle and the owner sees m_ready TIMEOUT cycles after grant.
  assign to_hit  = (to_cnt_q == CNT_W'(TIMEOUT - 1));
  assign arb_err = arb_err_q;
`else
  assign arb_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= GID_W'(N_REQ - 1);
      m_ready <= '0;
      m_rdata <= '0;
      s_valid <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
      s_gid   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      to_cnt_q  <= '0;
      arb_err_q <= 1'b0;
`endif
    end else begin
      m_ready <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            s_addr  <= m_addr[32*int'(pick_idx) +: 32];
            s_wdata <= m_wdata[32*int'(pick_idx) +: 32];
            s_wstrb <= m_wstrb[4*int'(pick_idx) +: 4];
            s_gid   <= pick_idx;
            s_valid <= 1'b1;
            last_q  <= pick_idx;
            state_q <= ST_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        ST_BUSY: begin
          if (s_ready) begin
            s_valid        <= 1'b0;
            m_rdata        <= s_rdata;
            m_ready[s_gid] <= 1'b1;
            state_q        <= ST_IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
          end else if (to_hit) begin
            s_valid        <= 1'b0;
            m_rdata        <= 32'hDEAD_BEEF;
            m_ready[s_gid] <= 1'b1;
            arb_err_q      <= 1'b1;
            state_q        <= ST_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
